control_unit: RTL and testbench

Multicycle FSM that drives every control input of the CPU datapath: PC, IR, A/B, ALUOut, EPC and register-file write enables, memory write, and all mux/ALU/shifter selects. It decodes the opcode and funct fields held in the instruction register and sequences fetch, decode, execute, memory and writeback. It takes flag feedback from the ALU. It is instantiated beside the datapath inside `CPU` and is the sole source of its control wires.

---
 rtl/cpu_ctrl_pkg.sv | 141 ++++++++++++++
 rtl/control_unit_if.sv | 47 ++++
 rtl/ctrl_out_decode.sv | 123 ++++++++++++
 rtl/control_unit.sv | 84 ++++++++
 tb/tb_control_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_ctrl_pkg : state, opcode/funct and select encodings shared by   |
// |                the multicycle control unit and its datapath.        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_ctrl_pkg;

  typedef logic [4:0] state_t;

  localparam state_t ST_RESET   = 5'd0;
  localparam state_t ST_FETCH   = 5'd1;
  localparam state_t ST_FETCH2  = 5'd2;
  localparam state_t ST_DECODE  = 5'd3;
  localparam state_t ST_EXEC_R  = 5'd4;
  localparam state_t ST_WB_R    = 5'd5;
  localparam state_t ST_SH_LOAD = 5'd6;
  localparam state_t ST_SH_OP   = 5'd7;
  localparam state_t ST_SH_WB   = 5'd8;
  localparam state_t ST_EXEC_I  = 5'd9;
  localparam state_t ST_WB_I    = 5'd10;
  localparam state_t ST_ADDR    = 5'd11;
  localparam state_t ST_MEM_RD  = 5'd12;
  localparam state_t ST_LW_WB   = 5'd13;
  localparam state_t ST_SW      = 5'd14;
  localparam state_t ST_BR      = 5'd15;
  localparam state_t ST_J       = 5'd16;
  localparam state_t ST_EXC_OVF = 5'd17;
  localparam state_t ST_EXC_OP  = 5'd18;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_A  = 1'b1;
  localparam logic       SHSRC_B = 1'b0;
  localparam logic       SHSRC_A = 1'b1;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic       IORD_PC     = 1'b0;
  localparam logic       IORD_ALUOUT = 1'b1;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] REGDST_SP = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MEM    = 2'b01;
  localparam logic [1:0] M2R_SHIFT  = 2'b10;
  localparam logic [1:0] M2R_CONST  = 2'b11;

  localparam logic [1:0] SHAMT_FIELD = 2'b00;
  localparam logic [1:0] SHAMT_B     = 2'b01;

  localparam logic [2:0] SHREG_HOLD = 3'b000;
  localparam logic [2:0] SHREG_LOAD = 3'b001;
  localparam logic [2:0] SHREG_SLL  = 3'b010;
  localparam logic [2:0] SHREG_SRL  = 3'b011;
  localparam logic [2:0] SHREG_SRA  = 3'b100;

  localparam logic [2:0] PCSRC_ALU     = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT  = 3'b001;
  localparam logic [2:0] PCSRC_JUMP    = 3'b010;
  localparam logic [2:0] PCSRC_EXC_OVF = 3'b100;
  localparam logic [2:0] PCSRC_EXC_OP  = 3'b101;

  localparam logic [31:0] C_RESET_SP = 32'd227;
  localparam logic [31:0] C_VEC_OP   = 32'd254;
  localparam logic [31:0] C_VEC_OVF  = 32'd255;

  typedef struct packed {
    logic       pc_write;
    logic       wr;
    logic       sel_ir;
    logic       ab_load;
    logic       aluout_load;
    logic       epc_load;
    logic       reg_write;
    logic       sel_alusrca;
    logic       sel_shift_src;
    logic [1:0] sel_alusrcb;
    logic       sel_iord;
    logic [1:0] sel_regdst;
    logic [1:0] sel_mem_to_reg;
    logic [1:0] sel_shift_amt;
    logic [2:0] sel_shift_reg;
    logic [2:0] alu_op;
    logic [2:0] sel_pc_source;
  } ctrl_t;

  function automatic logic is_arith_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

  function automatic logic is_shift_funct(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

  function automatic logic [2:0] alu_op_for_funct(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_NOP;
    endcase
  endfunction

  function automatic logic [2:0] shift_op_for_funct(input logic [5:0] funct);
    case (funct)
      FN_SRL:  return SHREG_SRL;
      FN_SRA:  return SHREG_SRA;
      default: return SHREG_SLL;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// +--------------------------------------------------------------------+
// | control_unit_if : IR fields, ALU flags and every datapath control   |
// |                   wire exchanged between control unit and datapath. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface control_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       overflow;

  logic       PC_write;
  logic       wr;
  logic       sel_ir;
  logic       AB_load;
  logic       aluout_load;
  logic       EPC_load;
  logic       reg_write;
  logic       sel_alusrca;
  logic       sel_shift_src;
  logic [1:0] sel_alusrcb;
  logic       sel_IorD;
  logic [1:0] sel_RegDst;
  logic [1:0] sel_mem_to_reg;
  logic [1:0] sel_shift_amt;
  logic [2:0] sel_shift_reg;
  logic [2:0] alu_op;
  logic [2:0] sel_pc_source;

  modport master (
    input  opcode, funct, alu_zero, overflow,
    output PC_write, wr, sel_ir, AB_load, aluout_load, EPC_load, reg_write,
           sel_alusrca, sel_shift_src, sel_alusrcb, sel_IorD, sel_RegDst,
           sel_mem_to_reg, sel_shift_amt, sel_shift_reg, alu_op, sel_pc_source
  );

  modport slave (
    output opcode, funct, alu_zero, overflow,
    input  PC_write, wr, sel_ir, AB_load, aluout_load, EPC_load, reg_write,
           sel_alusrca, sel_shift_src, sel_alusrcb, sel_IorD, sel_RegDst,
           sel_mem_to_reg, sel_shift_amt, sel_shift_reg, alu_op, sel_pc_source
  );
endinterface

`default_nettype wire

// File: rtl/ctrl_out_decode.sv
// +--------------------------------------------------------------------+
// | ctrl_out_decode : Moore state-to-controls decoder; the only flag    |
// |                   path is the beq/bne PC_write gate.                |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module ctrl_out_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_RESET: begin
        // Writes 227 into $29 on the first edge after reset falls.
        ctrl.reg_write      = 1'b1;
        ctrl.sel_regdst     = REGDST_SP;
        ctrl.sel_mem_to_reg = M2R_CONST;
      end
      ST_FETCH: begin
        ctrl.sel_iord    = IORD_PC;
        ctrl.sel_alusrca = SRCA_PC;
        ctrl.sel_alusrcb = SRCB_FOUR;
        ctrl.alu_op      = ALU_ADD;
      end
      ST_FETCH2: begin
        ctrl.sel_ir        = 1'b1;
        ctrl.pc_write      = 1'b1;
        ctrl.sel_alusrca   = SRCA_PC;
        ctrl.sel_alusrcb   = SRCB_FOUR;
        ctrl.alu_op        = ALU_ADD;
        ctrl.sel_pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        ctrl.ab_load     = 1'b1;
        ctrl.aluout_load = 1'b1;
        ctrl.sel_alusrca = SRCA_PC;
        ctrl.sel_alusrcb = SRCB_IMM_SL2;
        ctrl.alu_op      = ALU_ADD;
      end
      ST_EXEC_R: begin
        ctrl.sel_alusrca = SRCA_A;
        ctrl.sel_alusrcb = SRCB_B;
        ctrl.alu_op      = alu_op_for_funct(funct);
        ctrl.aluout_load = 1'b1;
      end
      ST_WB_R: begin
        ctrl.reg_write      = 1'b1;
        ctrl.sel_regdst     = REGDST_RD;
        ctrl.sel_mem_to_reg = M2R_ALUOUT;
      end
      ST_SH_LOAD: begin
        ctrl.sel_shift_src = SHSRC_B;
        ctrl.sel_shift_amt = SHAMT_FIELD;
        ctrl.sel_shift_reg = SHREG_LOAD;
      end
      ST_SH_OP: begin
        ctrl.sel_shift_amt = SHAMT_FIELD;
        ctrl.sel_shift_reg = shift_op_for_funct(funct);
      end
      ST_SH_WB: begin
        ctrl.reg_write      = 1'b1;
        ctrl.sel_regdst     = REGDST_RD;
        ctrl.sel_mem_to_reg = M2R_SHIFT;
      end
      ST_EXEC_I, ST_ADDR: begin
        ctrl.sel_alusrca = SRCA_A;
        ctrl.sel_alusrcb = SRCB_IMM;
        ctrl.alu_op      = ALU_ADD;
        ctrl.aluout_load = 1'b1;
      end
      ST_WB_I: begin
        ctrl.reg_write      = 1'b1;
        ctrl.sel_regdst     = REGDST_RT;
        ctrl.sel_mem_to_reg = M2R_ALUOUT;
      end
      ST_MEM_RD: begin
        ctrl.sel_iord = IORD_ALUOUT;
      end
      ST_LW_WB: begin
        ctrl.sel_iord       = IORD_ALUOUT;
        ctrl.reg_write      = 1'b1;
        ctrl.sel_regdst     = REGDST_RT;
        ctrl.sel_mem_to_reg = M2R_MEM;
      end
      ST_SW: begin
        ctrl.sel_iord = IORD_ALUOUT;
        ctrl.wr       = 1'b1;
      end
      ST_BR: begin
        ctrl.sel_alusrca   = SRCA_A;
        ctrl.sel_alusrcb   = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.sel_pc_source = PCSRC_ALUOUT;
        ctrl.pc_write      = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
      end
      ST_J: begin
        ctrl.pc_write      = 1'b1;
        ctrl.sel_pc_source = PCSRC_JUMP;
      end
      ST_EXC_OVF, ST_EXC_OP: begin
        // ALU computes PC-4 so EPC holds the faulting instruction address.
        ctrl.sel_alusrca   = SRCA_PC;
        ctrl.sel_alusrcb   = SRCB_FOUR;
        ctrl.alu_op        = ALU_SUB;
        ctrl.epc_load      = 1'b1;
        ctrl.pc_write      = 1'b1;
        ctrl.sel_pc_source = (state == ST_EXC_OVF) ? PCSRC_EXC_OVF : PCSRC_EXC_OP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// +--------------------------------------------------------------------+
// | control_unit : multicycle CPU sequencer (fetch/decode/exec/mem/wb)  |
// |                driving every datapath control through ctrl.         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  control_unit_if.master  ctrl
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_out;

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_FETCH2;
      ST_FETCH2: state_d = ST_DECODE;
      ST_DECODE: begin
        case (ctrl.opcode)
          OP_RTYPE: begin
            if (is_arith_funct(ctrl.funct))      state_d = ST_EXEC_R;
            else if (is_shift_funct(ctrl.funct)) state_d = ST_SH_LOAD;
            else                                 state_d = ST_EXC_OP;
          end
          OP_ADDI:       state_d = ST_EXEC_I;
          OP_LW, OP_SW:  state_d = ST_ADDR;
          OP_BEQ, OP_BNE: state_d = ST_BR;
          OP_J:          state_d = ST_J;
          default:       state_d = ST_EXC_OP;
        endcase
      end
      // A logical AND cannot overflow, so the flag is ignored for it.
      ST_EXEC_R:  state_d = (ctrl.overflow && (ctrl.funct != FN_AND)) ? ST_EXC_OVF : ST_WB_R;
      ST_EXEC_I:  state_d = ctrl.overflow ? ST_EXC_OVF : ST_WB_I;
      ST_SH_LOAD: state_d = ST_SH_OP;
      ST_SH_OP:   state_d = ST_SH_WB;
      ST_ADDR:    state_d = (ctrl.opcode == OP_LW) ? ST_MEM_RD : ST_SW;
      ST_MEM_RD:  state_d = ST_LW_WB;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  ctrl_out_decode u_decode (
    .state    (state_q),
    .opcode   (ctrl.opcode),
    .funct    (ctrl.funct),
    .alu_zero (ctrl.alu_zero),
    .ctrl     (ctrl_out)
  );

  assign ctrl.PC_write       = ctrl_out.pc_write;
  assign ctrl.wr             = ctrl_out.wr;
  assign ctrl.sel_ir         = ctrl_out.sel_ir;
  assign ctrl.AB_load        = ctrl_out.ab_load;
  assign ctrl.aluout_load    = ctrl_out.aluout_load;
  assign ctrl.EPC_load       = ctrl_out.epc_load;
  assign ctrl.reg_write      = ctrl_out.reg_write;
  assign ctrl.sel_alusrca    = ctrl_out.sel_alusrca;
  assign ctrl.sel_shift_src  = ctrl_out.sel_shift_src;
  assign ctrl.sel_alusrcb    = ctrl_out.sel_alusrcb;
  assign ctrl.sel_IorD       = ctrl_out.sel_iord;
  assign ctrl.sel_RegDst     = ctrl_out.sel_regdst;
  assign ctrl.sel_mem_to_reg = ctrl_out.sel_mem_to_reg;
  assign ctrl.sel_shift_amt  = ctrl_out.sel_shift_amt;
  assign ctrl.sel_shift_reg  = ctrl_out.sel_shift_reg;
  assign ctrl.alu_op         = ctrl_out.alu_op;
  assign ctrl.sel_pc_source  = ctrl_out.sel_pc_source;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// +--------------------------------------------------------------------+
// | tb_control_unit : scoreboard bench for control_unit, one expected   |
// |                   control word queued per cycle of each instruction.|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_control_unit;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    ctrl_t exp;
  } item_t;

  item_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  ctrl_t v_reset, v_fetch, v_fetch2, v_decode, v_wb_r, v_sh_load, v_sh_wb;
  ctrl_t v_exec_i, v_wb_i, v_mem_rd, v_lw_wb, v_sw, v_j;

  // Argument order follows the ctrl_t fields, MSB first.
  function automatic ctrl_t mk(input logic pcw, input logic wr, input logic ir,
                               input logic ab, input logic ao, input logic epc,
                               input logic rw, input logic srca, input logic shsrc,
                               input logic [1:0] srcb, input logic iord,
                               input logic [1:0] rd, input logic [1:0] m2r,
                               input logic [1:0] sha, input logic [2:0] shr,
                               input logic [2:0] aop, input logic [2:0] pcs);
    ctrl_t c;
    c = {pcw, wr, ir, ab, ao, epc, rw, srca, shsrc, srcb, iord, rd, m2r, sha, shr, aop, pcs};
    return c;
  endfunction

  function automatic ctrl_t observed();
    ctrl_t c;
    c = {bus.PC_write, bus.wr, bus.sel_ir, bus.AB_load, bus.aluout_load, bus.EPC_load,
         bus.reg_write, bus.sel_alusrca, bus.sel_shift_src, bus.sel_alusrcb, bus.sel_IorD,
         bus.sel_RegDst, bus.sel_mem_to_reg, bus.sel_shift_amt, bus.sel_shift_reg,
         bus.alu_op, bus.sel_pc_source};
    return c;
  endfunction

  function automatic ctrl_t v_exec_r(input logic [2:0] aop);
    return mk(0,0,0,0,1,0,0,1,0,2'b00,0,2'b00,2'b00,2'b00,3'b000,aop,3'b000);
  endfunction

  function automatic ctrl_t v_sh_op(input logic [2:0] shr);
    return mk(0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,shr,3'b000,3'b000);
  endfunction

  function automatic ctrl_t v_br(input logic pcw);
    return mk(pcw,0,0,0,0,0,0,1,0,2'b00,0,2'b00,2'b00,2'b00,3'b000,3'b010,3'b001);
  endfunction

  function automatic ctrl_t v_exc(input logic [2:0] pcs);
    return mk(1,0,0,0,0,1,0,0,0,2'b01,0,2'b00,2'b00,2'b00,3'b000,3'b010,pcs);
  endfunction

  task automatic check_word(input string tag, input ctrl_t got, input ctrl_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %07h expected %07h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input ctrl_t exp);
    item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic pop_check();
    item_t it;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry expected one");
    end else begin
      it = sb.pop_front();
      check_word(it.tag, observed(), it.exp);
    end
  endtask

  // One queued entry per clock; the queue length bounds the wait.
  task automatic drain();
    while (sb.size() > 0) begin
      @(negedge clk);
      pop_check();
    end
  endtask

  task automatic start_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic zero);
    bus.opcode   = op;
    bus.funct    = fn;
    bus.overflow = ovf;
    bus.alu_zero = zero;
    push({name, "/FETCH"},  v_fetch);
    push({name, "/FETCH2"}, v_fetch2);
    push({name, "/DECODE"}, v_decode);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    v_reset   = mk(0,0,0,0,0,0,1,0,0,2'b00,0,2'b11,2'b11,2'b00,3'b000,3'b000,3'b000);
    v_fetch   = mk(0,0,0,0,0,0,0,0,0,2'b01,0,2'b00,2'b00,2'b00,3'b000,3'b001,3'b000);
    v_fetch2  = mk(1,0,1,0,0,0,0,0,0,2'b01,0,2'b00,2'b00,2'b00,3'b000,3'b001,3'b000);
    v_decode  = mk(0,0,0,1,1,0,0,0,0,2'b11,0,2'b00,2'b00,2'b00,3'b000,3'b001,3'b000);
    v_wb_r    = mk(0,0,0,0,0,0,1,0,0,2'b00,0,2'b01,2'b00,2'b00,3'b000,3'b000,3'b000);
    v_sh_load = mk(0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b001,3'b000,3'b000);
    v_sh_wb   = mk(0,0,0,0,0,0,1,0,0,2'b00,0,2'b01,2'b10,2'b00,3'b000,3'b000,3'b000);
    v_exec_i  = mk(0,0,0,0,1,0,0,1,0,2'b10,0,2'b00,2'b00,2'b00,3'b000,3'b001,3'b000);
    v_wb_i    = mk(0,0,0,0,0,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000,3'b000,3'b000);
    v_mem_rd  = mk(0,0,0,0,0,0,0,0,0,2'b00,1,2'b00,2'b00,2'b00,3'b000,3'b000,3'b000);
    v_lw_wb   = mk(0,0,0,0,0,0,1,0,0,2'b00,1,2'b00,2'b01,2'b00,3'b000,3'b000,3'b000);
    v_sw      = mk(0,1,0,0,0,0,0,0,0,2'b00,1,2'b00,2'b00,2'b00,3'b000,3'b000,3'b000);
    v_j       = mk(1,0,0,0,0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000,3'b000,3'b010);

    bus.opcode = 6'h00; bus.funct = 6'h00; bus.overflow = 1'b0; bus.alu_zero = 1'b0;

    repeat (3) @(negedge clk);
    push("reset/held", v_reset);
    pop_check();
    reset = 1'b0;
    #1;
    push("reset/released", v_reset);
    pop_check();

    start_instr("add", OP_RTYPE, FN_ADD, 1'b0, 1'b0);
    push("add/EXEC_R", v_exec_r(3'b001));
    push("add/WB_R", v_wb_r);
    drain();

    start_instr("sub_ovf", OP_RTYPE, FN_SUB, 1'b1, 1'b0);
    push("sub_ovf/EXEC_R", v_exec_r(3'b010));
    push("sub_ovf/EXC_OVF", v_exc(3'b100));
    drain();

    start_instr("and_ovf", OP_RTYPE, FN_AND, 1'b1, 1'b0);
    push("and_ovf/EXEC_R", v_exec_r(3'b011));
    push("and_ovf/WB_R", v_wb_r);
    drain();

    start_instr("addi_ovf", OP_ADDI, 6'h15, 1'b1, 1'b0);
    push("addi_ovf/EXEC_I", v_exec_i);
    push("addi_ovf/EXC_OVF", v_exc(3'b100));
    drain();

    start_instr("addi", OP_ADDI, 6'h15, 1'b0, 1'b0);
    push("addi/EXEC_I", v_exec_i);
    push("addi/WB_I", v_wb_i);
    drain();

    start_instr("beq_z1", OP_BEQ, 6'h00, 1'b0, 1'b1);
    push("beq_z1/BR", v_br(1'b1));
    drain();
    start_instr("beq_z0", OP_BEQ, 6'h00, 1'b0, 1'b0);
    push("beq_z0/BR", v_br(1'b0));
    drain();
    start_instr("bne_z1", OP_BNE, 6'h00, 1'b0, 1'b1);
    push("bne_z1/BR", v_br(1'b0));
    drain();
    start_instr("bne_z0", OP_BNE, 6'h00, 1'b0, 1'b0);
    push("bne_z0/BR", v_br(1'b1));
    drain();

    start_instr("lw", OP_LW, 6'h04, 1'b1, 1'b0);
    push("lw/ADDR", v_exec_i);
    push("lw/MEM_RD", v_mem_rd);
    push("lw/LW_WB", v_lw_wb);
    drain();

    start_instr("sw", OP_SW, 6'h08, 1'b0, 1'b0);
    push("sw/ADDR", v_exec_i);
    push("sw/SW", v_sw);
    drain();

    start_instr("j", OP_J, 6'h20, 1'b0, 1'b0);
    push("j/J", v_j);
    drain();

    start_instr("bad_op", 6'h3F, 6'h20, 1'b0, 1'b0);
    push("bad_op/EXC_OP", v_exc(3'b101));
    drain();

    start_instr("bad_funct", OP_RTYPE, 6'h21, 1'b0, 1'b0);
    push("bad_funct/EXC_OP", v_exc(3'b101));
    drain();

    start_instr("sll", OP_RTYPE, FN_SLL, 1'b0, 1'b0);
    push("sll/SH_LOAD", v_sh_load);
    push("sll/SH_OP", v_sh_op(3'b010));
    push("sll/SH_WB", v_sh_wb);
    drain();

    start_instr("sra", OP_RTYPE, FN_SRA, 1'b0, 1'b0);
    push("sra/SH_LOAD", v_sh_load);
    push("sra/SH_OP", v_sh_op(3'b100));
    push("sra/SH_WB", v_sh_wb);
    drain();

    // Reset lands mid-instruction, well before the next rising edge.
    start_instr("srl", OP_RTYPE, FN_SRL, 1'b0, 1'b0);
    push("srl/SH_LOAD", v_sh_load);
    push("srl/SH_OP", v_sh_op(3'b011));
    drain();
    reset = 1'b1;
    #1;
    push("srl/async_reset", v_reset);
    pop_check();
    @(negedge clk);
    push("srl/reset_held", v_reset);
    pop_check();
    reset = 1'b0;

    start_instr("j_after_reset", OP_J, 6'h00, 1'b0, 1'b0);
    push("j_after_reset/J", v_j);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
